kws_weight_loader: RTL and testbench
====================================

Name: kws_weight_loader

Overview:
- Sequences parameter loading for the KWS CNN datapath (conv1, conv2, fc1, fc2 weights and biases).
- Accepts one 16-bit word stream from the host/DMA side with a valid/ready handshake.
- Steers each word to a segment-select, word-address and write-enable bus that feeds the layer parameter buffers.
- Emits the one-cycle load strobe for each segment when that segment is complete, in fixed layer order.

Parameters:
- DATA_W, 16, width of one stream word (equals ACTIV_BITS).
- ADDR_W, 14, word-address width; must hold the largest segment size minus 1.
- SZ_C1W, 72, conv1 weight words (8x3x3).
- SZ_C1B, 8, conv1 bias words.
- SZ_C2W, 576, conv2 weight words (8x8x3x3).
- SZ_C2B, 8, conv2 bias words.
- SZ_F1W, 10240, fc1 weight words (64x160).
- SZ_F1B, 64, fc1 bias words.
- SZ_F2W, 640, fc2 weight words (64x10).
- SZ_F2B, 10, fc2 bias words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a load sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel of the sequence in progress.
- seg_en  in  8  per-segment enable, sampled on start. Bit index: 0 C1W, 1 C1B, 2 C2W, 3 C2B, 4 F1W, 5 F1B, 6 F2W, 7 F2B.
- in_data  in  DATA_W  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- wr_seg  out  3  segment index of the current write.
- wr_addr  out  ADDR_W  word index within the segment.
- wr_data  out  DATA_W  word being written.
- wr_en  out  1  write strobe.
- load_strobe  out  8  one-hot, one-cycle commit pulse, mapped to the layers' load_weights/load_biases inputs.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when the sequence is complete.

Behaviour:
- FSM states: IDLE, STREAM, COMMIT.
- Registers: seg (3b), cnt (ADDR_W), en_mask (8b).
- Reset (rst=1, or abort=1 outside IDLE; rst has priority):
  - state=IDLE, seg=0, cnt=0.
  - All outputs are 0: wr_en, wr_seg, wr_addr, wr_data, load_strobe, busy, done.
  - The in-progress segment receives no strobe; done is not pulsed on abort.
  - abort in IDLE has no effect.
- in_ready is combinational: 1 iff state==STREAM and abort==0. A transfer occurs when in_valid & in_ready.
- IDLE:
  - On start, latch en_mask=seg_en.
  - If en_mask!=0: seg=lowest set bit, cnt=0, state=STREAM.
  - If seg_en==0: done=1 on the next cycle, state stays IDLE.
  - start while busy is ignored.
- STREAM:
  - Each transfer registers wr_en=1, wr_seg=seg, wr_addr=cnt, wr_data=in_data in the following cycle (1-cycle latency).
  - cnt increments on each transfer.
  - On the transfer with cnt==SZ(seg)-1, state=COMMIT. No further word is accepted until the next segment starts.
  - wr_en=0 in any cycle following a non-transfer cycle.
- COMMIT (exactly 1 cycle; wr_en carries the last word in this cycle):
  - Next cycle: load_strobe=1<<seg.
  - If a higher enabled segment exists: seg=next set bit of en_mask above seg, cnt=0, state=STREAM. in_ready rises in the same cycle as load_strobe.
  - Otherwise: done=1 in the same cycle as load_strobe, state=IDLE.
- Last-word timing: if the last word is accepted in cycle N, wr_en is high in N+1 and load_strobe in N+2.
- busy: registered, equals (state!=IDLE); it is low in the done cycle.
- Word k of segment s corresponds to bits [DATA_W*k+DATA_W-1 : DATA_W*k] of that layer's parameter bus.
- Disabled segments are skipped: no words consumed, no strobe.
- A new start is accepted in the cycle after done.

Test Plan:
- Bench sizes: all SZ_*=4, ADDR_W=2.
1. seg_en=8'hFF, in_valid held 1, in_data=0..31 -> 32 wr_en pulses.
   - wr_seg/wr_addr run (0,0)..(7,3).
   - load_strobe 8'h01..8'h80, each 2 cycles after its segment's last word; 1-cycle in_ready gap per boundary.
   - done coincides with 8'h80; busy falls the same cycle.
2. Same as 1 with in_valid toggled 1,0,1,0 -> wr_en follows transfers with 1-cycle latency; no duplicated or dropped words; wr_addr contiguous.
3. seg_en=8'b1000_0101 -> only segments 0, 2, 7 are written (12 words).
   - load_strobe sequence 01, 04, 80, then done.
   - in_ready=0 after done.
4. start with seg_en=0 -> done pulse 1 cycle later, wr_en and load_strobe never set, busy stays 0.
5. abort asserted after 2 words of segment 2 -> in_ready drops that cycle, busy=0 next cycle, no strobe 8'h04, no done.
   - Restart with seg_en=8'h04 loads addresses 0..3 cleanly.
6. start pulsed again mid-sequence, and rst pulsed mid-segment -> restart ignored; rst returns all outputs to 0 next cycle, and a subsequent start begins at wr_addr 0.

Source files
------------

// File: rtl/kws_weight_loader.sv
// kws_weight_loader: steers a valid/ready word stream into the CNN parameter buffers, segment by segment, with per-segment commit strobes.
module kws_weight_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int SZ_C1W = 72,
  parameter int SZ_C1B = 8,
  parameter int SZ_C2W = 576,
  parameter int SZ_C2B = 8,
  parameter int SZ_F1W = 10240,
  parameter int SZ_F1B = 64,
  parameter int SZ_F2W = 640,
  parameter int SZ_F2B = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        seg_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2:0]        wr_seg,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [7:0]        load_strobe,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, STREAM, COMMIT} state_t;
  state_t r_state, w_nxt;
  logic [2:0] r_seg;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0] r_en_mask, w_above;
  logic w_xfer, w_kill, w_last, w_more;
  function automatic int seg_size(input logic [2:0] s);
    case (s)
      3'd0: seg_size = SZ_C1W;
      3'd1: seg_size = SZ_C1B;
      3'd2: seg_size = SZ_C2W;
      3'd3: seg_size = SZ_C2B;
      3'd4: seg_size = SZ_F1W;
      3'd5: seg_size = SZ_F1B;
      3'd6: seg_size = SZ_F2W;
      default: seg_size = SZ_F2B;
    endcase
  endfunction
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  always_comb begin
    in_ready = r_state == STREAM && !abort;
    w_xfer = in_valid && in_ready;
    w_kill = abort && r_state != IDLE;
    w_last = r_cnt == ADDR_W'(seg_size(r_seg) - 1);
    w_above = r_en_mask & (8'hFE << r_seg);
    w_more = |w_above;
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = start && |seg_en ? STREAM : IDLE;
      STREAM: w_nxt = w_xfer && w_last ? COMMIT : STREAM;
      default: w_nxt = w_more ? STREAM : IDLE;
    endcase
    if (w_kill) w_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // abort clears the datapath like rst, so the interrupted segment never strobes
  always_ff @(posedge clk) begin
    if (rst || w_kill) begin
      r_seg <= '0;
      r_cnt <= '0;
      r_en_mask <= '0;
      wr_en <= 1'b0;
      wr_seg <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      load_strobe <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      wr_en <= w_xfer;
      load_strobe <= r_state == COMMIT ? 8'd1 << r_seg : 8'd0;
      done <= (r_state == IDLE && start && seg_en == 8'd0) || (r_state == COMMIT && !w_more);
      busy <= w_nxt != IDLE;
      if (r_state == IDLE && start) begin
        r_en_mask <= seg_en;
        r_seg <= lowest(seg_en);
        r_cnt <= '0;
      end
      if (w_xfer) begin
        wr_seg <= r_seg;
        wr_addr <= r_cnt;
        wr_data <= in_data;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == COMMIT && w_more) begin
        r_seg <= lowest(w_above);
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_kws_weight_loader.sv
// tb_kws_weight_loader: randomized and directed stimulus checked every cycle against a segment-queue reference model.
module tb_kws_weight_loader;
  localparam int SZ = 4;
  logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
  logic [7:0] seg_en = 0;
  logic [15:0] in_data = 0;
  logic in_ready, wr_en, busy, done;
  logic [2:0] wr_seg;
  logic [1:0] wr_addr;
  logic [15:0] wr_data;
  logic [7:0] load_strobe;
  int checks = 0, failures = 0;
  int segq[$];
  int m_k = 0;
  bit m_active = 0, m_gap = 0, m_valid = 0, last_hs = 0;
  logic e_wr_en = 0, e_busy = 0, e_done = 0;
  logic [2:0] e_wr_seg = 0;
  logic [1:0] e_wr_addr = 0;
  logic [15:0] e_wr_data = 0;
  logic [7:0] e_strobe = 0;
  int n_wr, n_done, word;
  logic [7:0] strobe_or;
  logic [15:0] last_data;
  kws_weight_loader #(.DATA_W(16), .ADDR_W(2), .SZ_C1W(SZ), .SZ_C1B(SZ), .SZ_C2W(SZ), .SZ_C2B(SZ),
    .SZ_F1W(SZ), .SZ_F1B(SZ), .SZ_F2W(SZ), .SZ_F2B(SZ)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seg_en(seg_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_seg(wr_seg), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .load_strobe(load_strobe), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // compare the edge that just happened, then advance the model over the coming edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", in_ready, m_active && !m_gap && !abort);
      chk("wr_en", wr_en, e_wr_en);
      chk("wr_seg", wr_seg, e_wr_seg);
      chk("wr_addr", wr_addr, e_wr_addr);
      chk("wr_data", wr_data, e_wr_data);
      chk("load_strobe", load_strobe, e_strobe);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
    end
    if (wr_en === 1'b1) begin n_wr++; last_data = wr_data; end
    if (load_strobe !== 8'hxx) strobe_or |= load_strobe;
    if (done === 1'b1) n_done++;
    last_hs = in_valid && in_ready === 1'b1;
    if (rst || (m_active && abort)) begin
      m_valid = m_valid | rst;
      {e_wr_en, e_wr_seg, e_wr_addr, e_wr_data, e_strobe, e_busy, e_done} = '0;
      m_active = 0; m_gap = 0; m_k = 0; segq.delete();
    end else begin
      e_wr_en = 0; e_strobe = 0; e_done = 0;
      if (!m_active) begin
        if (start) begin
          if (seg_en == 0) e_done = 1;
          else begin
            for (int i = 0; i < 8; i++) if (seg_en[i]) segq.push_back(i);
            m_active = 1; m_gap = 0; m_k = 0;
          end
        end
      end else if (m_gap) begin
        e_strobe = 8'd1 << segq[0];
        void'(segq.pop_front());
        if (segq.size() == 0) begin e_done = 1; m_active = 0; end
        else begin m_gap = 0; m_k = 0; end
      end else if (in_valid) begin
        e_wr_en = 1; e_wr_seg = 3'(segq[0]); e_wr_addr = 2'(m_k); e_wr_data = in_data;
        m_k++;
        if (m_k == SZ) m_gap = 1;
      end
      e_busy = m_active;
    end
  end
  task automatic run(input logic [7:0] se, input int vmode, input int abort_at, input int restart_at, input int rst_at);
    bit aborted = 0;
    n_wr = 0; n_done = 0; strobe_or = 0; word = 0; last_data = 0;
    start = 1; seg_en = se; in_valid = 0;
    tick();
    start = 0;
    for (int c = 0; c < 300; c++) begin
      if (last_hs) word++;
      seg_en = 8'($urandom);
      in_data = 16'(word);
      in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? c % 2 == 0 : 1'($urandom_range(0, 1));
      abort = abort_at >= 0 && word == abort_at && !aborted;
      if (abort) aborted = 1;
      start = c == restart_at;
      rst = c == rst_at;
      tick();
      if (!m_active && c >= 2) break;
    end
    chk("seq_timeout", m_active, 0);
    {in_valid, abort, start, rst} = '0;
    repeat (3) tick();
  endtask
  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_strobe", load_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    run(8'hFF, 0, -1, -1, -1);
    chk("t1_words", n_wr, 32);
    chk("t1_strobes", strobe_or, 8'hFF);
    chk("t1_done", n_done, 1);
    chk("t1_last_data", last_data, 31);
    run(8'hFF, 1, -1, -1, -1);
    chk("t2_words", n_wr, 32);
    chk("t2_last_data", last_data, 31);
    run(8'b1000_0101, 0, -1, -1, -1);
    chk("t3_words", n_wr, 12);
    chk("t3_strobes", strobe_or, 8'h85);
    run(8'h00, 0, -1, -1, -1);
    chk("t4_words", n_wr, 0);
    chk("t4_strobes", strobe_or, 0);
    chk("t4_done", n_done, 1);
    run(8'h07, 0, 10, -1, -1);
    chk("t5_words", n_wr, 10);
    chk("t5_strobes", strobe_or, 8'h03);
    chk("t5_done", n_done, 0);
    run(8'h04, 0, -1, -1, -1);
    chk("t5r_words", n_wr, 4);
    chk("t5r_strobes", strobe_or, 8'h04);
    run(8'hFF, 0, -1, 5, 14);
    chk("t6_done", n_done, 0);
    run(8'h01, 0, -1, -1, -1);
    chk("t6r_words", n_wr, 4);
    chk("t6r_strobes", strobe_or, 8'h01);
    for (int r = 0; r < 20; r++)
      run(8'($urandom), 2, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 20)) : -1, int'($urandom_range(0, 40)), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
